// File: rtl/sga_game.sv
// Snake game controller for a 6x6 LED matrix.
// The snake moves one cell every MOVE_CYCLES clocks, grows when it eats the
// apple, and the game ends on a wall or self collision or on reaching MAX_SIZE.
module sga_game #(
  parameter int MOVE_CYCLES = 50,
  parameter int MAX_SIZE    = 15
) (
  input  logic        clock,
  input  logic        restart,
  input  logic [3:0]  buttons,
  input  logic        start,
  input  logic        pause,
  output logic        finished,
  output logic        won,
  output logic        lost,
  output logic [4:0]  db_state,
  output logic [35:0] db_leds,
  output logic [3:0]  db_size
);

  localparam logic [4:0] S_IDLE   = 5'd0;
  localparam logic [4:0] S_INIT   = 5'd1;
  localparam logic [4:0] S_PLAY   = 5'd2;
  localparam logic [4:0] S_MOVE   = 5'd3;
  localparam logic [4:0] S_CHECK  = 5'd4;
  localparam logic [4:0] S_APPLE  = 5'd5;
  localparam logic [4:0] S_PAUSED = 5'd6;
  localparam logic [4:0] S_WON    = 5'd7;
  localparam logic [4:0] S_LOST   = 5'd8;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int TW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MOVE_CYCLES - 1);

  localparam logic [5:0] LFSR_SEED  = 6'b000001;
  localparam logic [5:0] INIT_HEAD  = 6'd14;
  localparam logic [5:0] INIT_TAIL  = 6'd13;
  localparam logic [5:0] INIT_APPLE = 6'd17;
  localparam logic [5:0] NUM_CELLS  = 6'd36;

  logic [4:0]    stateQ, stateD;
  logic [TW-1:0] timerQ, timerD;
  logic [1:0]    dirQ, dirD;
  logic [1:0]    pendQ, pendD;
  logic [3:0]    sizeQ, sizeD;
  logic [5:0]    appleQ, appleD;
  logic [5:0]    lfsrQ, lfsrD;
  logic [5:0]    snakeQ [MAX_SIZE];
  logic [5:0]    snakeD [MAX_SIZE];

  logic [1:0]    reqDir;
  logic [1:0]    refDir;
  logic          steerable;
  logic [5:0]    headCell;
  logic [2:0]    headRow;
  logic [2:0]    headCol;
  logic [5:0]    nextHead;
  logic          offGrid;
  logic [35:0]   snakeMask;
  logic [35:0]   image;
  logic          selfHit;
  logic [3:0]    sizeInc;

  assign headCell = snakeQ[0];
  assign headRow  = 3'(headCell / 6'd6);
  assign headCol  = 3'(headCell % 6'd6);
  assign sizeInc  = sizeQ + 4'd1;

  // Next head cell and wall detection, using the direction about to be committed
  always_comb begin
    nextHead = headCell;
    offGrid  = 1'b0;
    case (pendQ)
      DIR_RIGHT: begin
        offGrid  = (headCol == 3'd5);
        nextHead = headCell + 6'd1;
      end
      DIR_LEFT: begin
        offGrid  = (headCol == 3'd0);
        nextHead = headCell - 6'd1;
      end
      DIR_UP: begin
        offGrid  = (headRow == 3'd0);
        nextHead = headCell - 6'd6;
      end
      default: begin
        offGrid  = (headRow == 3'd5);
        nextHead = headCell + 6'd6;
      end
    endcase
  end

  // Occupancy of the valid snake segments, and self collision of the head
  always_comb begin
    snakeMask = '0;
    selfHit   = 1'b0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      if (i < int'(sizeQ) && snakeQ[i] < NUM_CELLS) begin
        snakeMask[snakeQ[i]] = 1'b1;
      end
      if (i > 0 && i < int'(sizeQ) && snakeQ[i] == headCell) begin
        selfHit = 1'b1;
      end
    end
  end

  // Matrix image: snake plus apple, blank until a game has been loaded
  always_comb begin
    image = snakeMask;
    if (sizeQ != 4'd0 && appleQ < NUM_CELLS) begin
      image[appleQ] = 1'b1;
    end
  end

  // Pending direction from the buttons: lowest bit wins, reversals are dropped
  always_comb begin
    pendD = pendQ;
    if (buttons[0]) begin
      reqDir = DIR_RIGHT;
    end else if (buttons[1]) begin
      reqDir = DIR_LEFT;
    end else if (buttons[2]) begin
      reqDir = DIR_UP;
    end else begin
      reqDir = DIR_DOWN;
    end
    refDir    = (stateQ == S_MOVE) ? pendQ : dirQ;
    steerable = (stateQ != S_IDLE) && (stateQ != S_WON) && (stateQ != S_LOST);
    if (stateQ == S_INIT) begin
      pendD = DIR_RIGHT;
    end else if (steerable && (buttons != 4'b0000) && (reqDir != (refDir ^ 2'b01))) begin
      pendD = reqDir;
    end
  end

  // Game FSM: timing, movement, scoring and apple placement
  always_comb begin
    stateD = stateQ;
    timerD = timerQ;
    dirD   = dirQ;
    sizeD  = sizeQ;
    appleD = appleQ;
    snakeD = snakeQ;
    lfsrD  = {lfsrQ[4:0], lfsrQ[5] ^ lfsrQ[4]};
    case (stateQ)
      S_IDLE: begin
        if (start) begin
          stateD = S_INIT;
        end
      end
      S_INIT: begin
        for (int i = 0; i < MAX_SIZE; i++) begin
          snakeD[i] = '0;
        end
        snakeD[0] = INIT_HEAD;
        snakeD[1] = INIT_TAIL;
        sizeD     = 4'd2;
        dirD      = DIR_RIGHT;
        appleD    = INIT_APPLE;
        timerD    = '0;
        stateD    = S_PLAY;
      end
      S_PLAY: begin
        if (pause) begin
          stateD = S_PAUSED;
        end else if (timerQ == TIMER_LAST) begin
          timerD = '0;
          stateD = S_MOVE;
        end else begin
          timerD = timerQ + TW'(1);
        end
      end
      S_PAUSED: begin
        if (!pause) begin
          stateD = S_PLAY;
        end
      end
      S_MOVE: begin
        dirD = pendQ;
        if (offGrid) begin
          stateD = S_LOST;
        end else begin
          for (int i = 1; i < MAX_SIZE; i++) begin
            snakeD[i] = snakeQ[i-1];
          end
          snakeD[0] = nextHead;
          stateD    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (selfHit) begin
          stateD = S_LOST;
        end else if (headCell == appleQ) begin
          sizeD = sizeInc;
          if (sizeInc == 4'(MAX_SIZE)) begin
            stateD = S_WON;
          end else begin
            stateD = S_APPLE;
          end
        end else begin
          stateD = S_PLAY;
        end
      end
      S_APPLE: begin
        if (lfsrQ < NUM_CELLS && !snakeMask[lfsrQ]) begin
          appleD = lfsrQ;
          stateD = S_PLAY;
        end
      end
      S_WON, S_LOST: begin
        if (start) begin
          stateD = S_INIT;
        end
      end
      default: begin
        stateD = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low restart
  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      stateQ <= S_IDLE;
      timerQ <= '0;
      dirQ   <= DIR_RIGHT;
      pendQ  <= DIR_RIGHT;
      sizeQ  <= '0;
      appleQ <= '0;
      lfsrQ  <= LFSR_SEED;
      for (int i = 0; i < MAX_SIZE; i++) begin
        snakeQ[i] <= '0;
      end
    end else begin
      stateQ <= stateD;
      timerQ <= timerD;
      dirQ   <= dirD;
      pendQ  <= pendD;
      sizeQ  <= sizeD;
      appleQ <= appleD;
      lfsrQ  <= lfsrD;
      snakeQ <= snakeD;
    end
  end

  assign won      = (stateQ == S_WON);
  assign lost     = (stateQ == S_LOST);
  assign finished = won | lost;
  assign db_state = stateQ;
  assign db_size  = sizeQ;
  assign db_leds  = image;

endmodule

// File: tb/tb_sga_game.sv
// Directed testbench for sga_game: reset, start, moves, apple, wall loss,
// pause/resume timing, reversal rejection and button priority.
module tb_sga_game;

  logic        clock;
  logic        restart;
  logic [3:0]  buttons;
  logic        start;
  logic        pause;
  logic        finished;
  logic        won;
  logic        lost;
  logic [4:0]  db_state;
  logic [35:0] db_leds;
  logic [3:0]  db_size;

  int assertCount;
  int failCount;
  int edges;

  sga_game #(.MOVE_CYCLES(50), .MAX_SIZE(15)) dut (
    .clock    (clock),
    .restart  (restart),
    .buttons  (buttons),
    .start    (start),
    .pause    (pause),
    .finished (finished),
    .won      (won),
    .lost     (lost),
    .db_state (db_state),
    .db_leds  (db_leds),
    .db_size  (db_size)
  );

  // 10 ns system clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic s, input logic p);
    buttons = b;
    start   = s;
    pause   = p;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitState(input string tag, input logic [4:0] code, input int budget, output int count);
    count = 0;
    while (db_state != code && count < budget) begin
      @(posedge clock);
      #1;
      count++;
    end
    checkOutput(tag, 64'(db_state), 64'(code));
  endtask

  task automatic pulseRestart();
    restart = 1'b0;
    tick(1);
    restart = 1'b1;
    tick(1);
  endtask

  task automatic startGame();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick(1);
  endtask

  // Directed test sequence
  initial begin
    assertCount = 0;
    failCount   = 0;
    restart     = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick(2);
    restart = 1'b1;
    tick(1);

    $display("[TB] reset state");
    checkOutput("rst state", 64'(db_state), 64'd0);
    checkOutput("rst leds", 64'(db_leds), 64'd0);
    checkOutput("rst size", 64'(db_size), 64'd0);
    checkOutput("rst finished", 64'(finished), 64'd0);
    checkOutput("rst won", 64'(won), 64'd0);
    checkOutput("rst lost", 64'(lost), 64'd0);

    $display("[TB] start and three moves right");
    startGame();
    checkOutput("start state", 64'(db_state), 64'd2);
    checkOutput("start size", 64'(db_size), 64'd2);
    checkOutput("start leds", 64'(db_leds), 64'h000026000);
    waitState("move1 reach", 5'd3, 200, edges);
    checkOutput("move period", 64'(edges), 64'd50);
    tick(2);
    checkOutput("move1 state", 64'(db_state), 64'd2);
    checkOutput("move1 leds", 64'(db_leds), 64'h00002C000);
    checkOutput("move1 size", 64'(db_size), 64'd2);
    waitState("move2 reach", 5'd3, 200, edges);
    tick(2);
    checkOutput("move2 leds", 64'(db_leds), 64'h000038000);
    waitState("move3 reach", 5'd3, 200, edges);
    tick(1);
    checkOutput("move3 check", 64'(db_state), 64'd4);
    tick(1);
    checkOutput("move3 apple", 64'(db_state), 64'd5);
    checkOutput("move3 size", 64'(db_size), 64'd3);
    waitState("apple placed", 5'd2, 200, edges);
    checkOutput("eat body", 64'(db_leds & 36'h000038000), 64'h000038000);
    checkOutput("eat bits", 64'($countones(db_leds)), 64'd4);

    $display("[TB] run into the right wall");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    waitState("wall lost", 5'd8, 300, edges);
    checkOutput("wall lost", 64'(lost), 64'd1);
    checkOutput("wall finished", 64'(finished), 64'd1);
    checkOutput("wall won", 64'(won), 64'd0);
    applyStimulus(4'b0110, 1'b0, 1'b1);
    tick(120);
    checkOutput("hold state", 64'(db_state), 64'd8);
    checkOutput("hold lost", 64'(lost), 64'd1);
    checkOutput("hold size", 64'(db_size), 64'd3);
    checkOutput("hold body", 64'(db_leds & 36'h000038000), 64'h000038000);
    checkOutput("hold bits", 64'($countones(db_leds)), 64'd4);

    $display("[TB] restart from lost, then async reset mid-game");
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(1);
    checkOutput("relaunch init", 64'(db_state), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick(1);
    checkOutput("relaunch state", 64'(db_state), 64'd2);
    checkOutput("relaunch leds", 64'(db_leds), 64'h000026000);
    checkOutput("relaunch lost", 64'(lost), 64'd0);
    tick(30);
    restart = 1'b0;
    #2;
    checkOutput("async state", 64'(db_state), 64'd0);
    checkOutput("async leds", 64'(db_leds), 64'd0);
    checkOutput("async size", 64'(db_size), 64'd0);
    checkOutput("async finished", 64'(finished), 64'd0);
    tick(1);
    restart = 1'b1;
    tick(3);
    checkOutput("idle holds", 64'(db_state), 64'd0);

    $display("[TB] pause freezes the move timer");
    startGame();
    tick(20);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick(200);
    checkOutput("paused state", 64'(db_state), 64'd6);
    checkOutput("paused leds", 64'(db_leds), 64'h000026000);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    waitState("resume move", 5'd3, 100, edges);
    checkOutput("resume remain", 64'(edges), 64'd31);
    tick(2);
    checkOutput("resume leds", 64'(db_leds), 64'h00002C000);

    $display("[TB] reversal ignored, up beats down, top wall");
    pulseRestart();
    startGame();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    waitState("rev reach", 5'd3, 200, edges);
    tick(2);
    checkOutput("rev leds", 64'(db_leds), 64'h00002C000);
    applyStimulus(4'b1100, 1'b0, 1'b0);
    waitState("up1 reach", 5'd3, 200, edges);
    tick(2);
    checkOutput("up1 leds", 64'(db_leds), 64'h000028200);
    waitState("up2 reach", 5'd3, 200, edges);
    tick(2);
    checkOutput("up2 leds", 64'(db_leds), 64'h000020208);
    waitState("top lost", 5'd8, 200, edges);
    checkOutput("top lost", 64'(lost), 64'd1);
    checkOutput("top won", 64'(won), 64'd0);
    checkOutput("top size", 64'(db_size), 64'd2);
    checkOutput("top leds", 64'(db_leds), 64'h000020208);

    applyStimulus(4'b0000, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
